// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu -- sequential ALU with a multi-cycle shift-add multiplier
//
// Seven of the operations complete in one cycle. The multiply takes one
// shift-add step per cycle for WIDTH cycles, and busy is high for that time.
// Result and flags are registered. They change only when done pulses.
//
// Parameters
//   WIDTH   operand/result width (2..64)
//   MUL_EN  1: func 3'b111 is the multi-cycle multiply
//           0: func 3'b111 is a single-cycle op that returns 0
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request strobe; accepted only while busy=0
//   ALUFunc    op select (sampled on acceptance)
//   a, b       operands (sampled on acceptance)
//   busy       high while a multiply is in progress
//   done       one-cycle pulse: ALUResult/flags valid for the finished request
//   ALUResult  registered result of the last completed op
//   zero       ALUResult == 0
//   carry      carry out (ADD) / borrow (SUB), else 0
//   overflow   signed overflow (ADD/SUB), else 0
// ============================================================================
module seq_alu #(
   parameter int WIDTH  = 16,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       ALUFunc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ALUResult,
   output logic             zero,
   output logic             carry,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] mcand_reg;   // multiplicand, shifted left each step
   logic [WIDTH-1:0] mplier_reg;  // multiplier, shifted right each step
   logic [WIDTH-1:0] acc_reg;     // modulo-2^WIDTH partial product
   logic [CW-1:0]    cnt_reg;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH-1:0] acc_next;

   // Single-cycle datapath. It works on the live inputs because a request
   // is captured on the same edge that accepts it.
   always_comb begin
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (ALUFunc)
         3'b000: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b001: begin
            alu_res = diff_ext[WIDTH-1:0];
            alu_c   = diff_ext[WIDTH];   // borrow: a < b unsigned
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b010: alu_res = a & b;
         3'b011: alu_res = ~a;
         3'b100: alu_res = a | b;
         3'b101: alu_res = a ^ b;
         3'b110: alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         default: alu_res = '0;          // MUL with MUL_EN=0
      endcase
   end

   // One shift-add step: add the multiplicand when the current multiplier
   // LSB is set. Only the low WIDTH bits are kept.
   always_comb begin
      acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         ALUResult  <= '0;
         zero       <= 1'b1;
         carry      <= 1'b0;
         overflow   <= 1'b0;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (ALUFunc == 3'b111 && MUL_EN != 0) begin
                     mcand_reg  <= a;
                     mplier_reg <= b;
                     acc_reg    <= '0;
                     cnt_reg    <= '0;
                     busy       <= 1'b1;
                     state_reg  <= MUL;
                  end else begin
                     ALUResult <= alu_res;
                     zero      <= (alu_res == '0);
                     carry     <= alu_c;
                     overflow  <= alu_v;
                     done      <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + 1'b1;
               // The last step publishes acc_next directly. This keeps busy
               // high for exactly WIDTH cycles and needs no extra state.
               if (cnt_reg == LAST_STEP) begin
                  ALUResult <= acc_next;
                  zero      <= (acc_next == '0);
                  carry     <= 1'b0;
                  overflow  <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu -- scoreboard bench for seq_alu (WIDTH=16, MUL_EN=1)
//
// Every request that should complete pushes its expected result and flags
// into a queue. The monitor pops one entry on each done pulse and compares
// it. A done pulse with an empty queue is an error. Directed checks cover
// latency, busy duration, back-to-back issue and reset behaviour.
// ============================================================================
module tb_seq_alu;

   typedef struct {
      logic [15:0] res;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  ALUFunc = 3'b000;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy;
   logic        done;
   logic [15:0] ALUResult;
   logic        zero;
   logic        carry;
   logic        overflow;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   logic [15:0] last_res = '0;

   seq_alu #(.WIDTH(16), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .start(start), .ALUFunc(ALUFunc), .a(a), .b(b),
      .busy(busy), .done(done), .ALUResult(ALUResult), .zero(zero),
      .carry(carry), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
      exp_t        e;
      logic [16:0] s;
      logic [31:0] p;
      e.res = '0; e.c = 1'b0; e.v = 1'b0;
      case (f)
         3'd0: begin
            s = {1'b0, x} + {1'b0, y};
            e.res = s[15:0];
            e.c = s[16];
            e.v = (x[15] == y[15]) && (e.res[15] != x[15]);
         end
         3'd1: begin
            e.res = x - y;
            e.c = (x < y);
            e.v = (x[15] != y[15]) && (e.res[15] != x[15]);
         end
         3'd2: e.res = x & y;
         3'd3: e.res = ~x;
         3'd4: e.res = x | y;
         3'd5: e.res = x ^ y;
         3'd6: e.res = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
         default: begin
            p = {16'b0, x} * {16'b0, y};
            e.res = p[15:0];
         end
      endcase
      e.z = (e.res == 16'd0);
      return e;
   endfunction

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("sb_res", ALUResult, e.res);
            check("sb_zero", zero, e.z);
            check("sb_carry", carry, e.c);
            check("sb_ovf", overflow, e.v);
            last_res = e.res;
            $display("done: res=0x%04h z=%0d c=%0d v=%0d", ALUResult, zero, carry, overflow);
         end
      end
   end

   // Drive a request from now until just after the next rising edge.
   task automatic issue(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y, input bit push);
      start = 1'b1; ALUFunc = f; a = x; b = y;
      if (push) sb.push_back(model(f, x, y));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Follow a multiply that was just accepted. Count busy cycles and stop at
   // the done cycle. It can fire a stray start on busy cycle stray_at, or
   // assert reset (with a competing start) on busy cycle rst_at.
   task automatic follow_mul(input int stray_at, input int rst_at, output int bc, output int dc);
      bit fin;
      bc = 0; dc = 0; fin = 0;
      for (int k = 1; k <= 40 && !fin; k++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            bc++;
            if (bc == stray_at) begin
               start = 1'b1; ALUFunc = 3'b001; a = 16'h0005; b = 16'h0001;
            end else begin
               start = 1'b0;
            end
            if (bc == 8) check("hold_during_mul", ALUResult, last_res);
            if (bc == rst_at) begin
               sb.delete();
               rst = 1'b1; start = 1'b1; ALUFunc = 3'b000; a = 16'h0002; b = 16'h0003;
               fin = 1;
            end
         end else if (done === 1'b1) begin
            dc = k;
            fin = 1;
         end
      end
      if (!fin) check("mul_timeout", 1, 0);
   endtask

   initial begin
      int bc, dc, d0;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", ALUResult, 16'h0000);
      check("rst_zero", zero, 1);
      check("rst_carry", carry, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;

      // ADD with carry-out and zero result
      issue(3'd0, 16'hFFFF, 16'h0001, 1);
      @(negedge clk);
      check("add_done", done, 1);
      check("add_busy", busy, 0);
      check("add_res", ALUResult, 16'h0000);
      check("add_zero", zero, 1);
      check("add_carry", carry, 1);
      check("add_ovf", overflow, 0);

      // SUB overflow, then SLT issued in the SUB done cycle
      issue(3'd1, 16'h8000, 16'h0001, 1);
      @(negedge clk);
      check("sub_res", ALUResult, 16'h7FFF);
      check("sub_ovf", overflow, 1);
      check("sub_carry", carry, 0);
      issue(3'd6, 16'hFFFF, 16'h0001, 1);
      @(negedge clk);
      check("slt_done", done, 1);
      check("slt_res", ALUResult, 16'h0001);
      check("slt_zero", zero, 0);

      // NOT / XOR and a few more single-cycle ops
      issue(3'd3, 16'h0F0F, 16'h0000, 1);
      @(negedge clk);
      check("not_res", ALUResult, 16'hF0F0);
      issue(3'd5, 16'hAAAA, 16'hAAAA, 1);
      @(negedge clk);
      check("xor_res", ALUResult, 16'h0000);
      check("xor_zero", zero, 1);
      issue(3'd2, 16'hF0F3, 16'h3C3C, 1);
      issue(3'd4, 16'h1200, 16'h0034, 1);
      issue(3'd1, 16'h0001, 16'h0002, 1);
      issue(3'd0, 16'h7FFF, 16'h0001, 1);
      @(negedge clk);

      // MUL 0x0123*0x0010 with operand change after accept and a stray SUB
      issue(3'd7, 16'h0123, 16'h0010, 1);
      a = 16'hDEAD; b = 16'hBEEF;
      follow_mul(3, 0, bc, dc);
      check("mul1_busy_cycles", bc, 16);
      check("mul1_done_cycle", dc, 17);
      check("mul1_res", ALUResult, 16'h1230);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // MUL 0xFFFF*0xFFFF, then ADD started in the done cycle
      issue(3'd7, 16'hFFFF, 16'hFFFF, 1);
      follow_mul(0, 0, bc, dc);
      check("mul2_busy_cycles", bc, 16);
      check("mul2_res", ALUResult, 16'h0001);
      check("mul2_carry", carry, 0);
      check("mul2_ovf", overflow, 0);
      check("mul2_done_busy", busy, 0);
      issue(3'd0, 16'h1234, 16'h1111, 1);
      @(negedge clk);
      check("b2b_done", done, 1);
      check("b2b_res", ALUResult, 16'h2345);
      @(negedge clk);
      check("b2b_single_pulse", done, 0);

      // MUL aborted by reset on busy cycle 5; the same-edge start is dropped
      issue(3'd7, 16'h00FF, 16'h0003, 1);
      follow_mul(0, 5, bc, dc);
      check("abort_busy_cycles", bc, 5);
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_res", ALUResult, 16'h0000);
      check("abort_zero", zero, 1);
      rst = 1'b0; start = 1'b0;
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      issue(3'd0, 16'h0002, 16'h0003, 1);
      @(negedge clk);
      check("post_rst_done", done, 1);
      check("post_rst_res", ALUResult, 16'h0005);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 2..64.
REQ-002 Parameter MUL_EN, default 1: 1 enables the multi-cycle multiply; 0 makes func 3'b111 behave as a single-cycle op returning 0.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 start  input  1  Request strobe; accepted only when busy=0.
REQ-006 ALUFunc  input  3  Op select, sampled when the request is accepted.
REQ-007 a  input  WIDTH  Operand A, sampled when the request is accepted.
REQ-008 b  input  WIDTH  Operand B, sampled when the request is accepted.
REQ-009 busy  output  1  High while a multiply is in progress.
REQ-010 done  output  1  One-cycle pulse marking that ALUResult and the flags are valid for the completed request.
REQ-011 ALUResult  output  WIDTH  Registered result of the last completed op.
REQ-012 zero  output  1  Registered; 1 when ALUResult == 0.
REQ-013 carry  output  1  Registered carry out (ADD) or borrow (SUB).
REQ-014 overflow  output  1  Registered signed overflow (ADD/SUB).

Function
REQ-015 ALUFunc encodings SHALL be:
- 000 ADD: a+b
- 001 SUB: a-b
- 010 AND: a&b
- 011 NOT: ~a
- 100 OR: a|b
- 101 XOR: a^b
- 110 SLT: signed a<b gives 1, else 0
- 111 MUL: low WIDTH bits of unsigned a*b
REQ-016 A request SHALL be accepted on a rising edge where start=1, busy=0 and rst=0; start at any other time SHALL be ignored, with no effect on any output.
REQ-017 Single-cycle ops (000-110) SHALL load ALUResult and the flags, and pulse done=1, in the cycle after acceptance (latency 1); busy SHALL stay 0.
REQ-018 FSM states SHALL be IDLE and MUL; there is no other state.
- IDLE to MUL on an accepted MUL request (MUL_EN=1).
- MUL to IDLE after WIDTH iterations.
REQ-019 On MUL acceptance, a, b and a zeroed accumulator SHALL be latched, and busy SHALL rise in the next cycle; operand changes after acceptance SHALL have no effect.
REQ-020 MUL SHALL perform one shift-add step per cycle, using a WIDTH-bit accumulator with the modulo-2^WIDTH product, and an iteration counter of width clog2(WIDTH+1).
REQ-021 MUL timing: busy=1 for exactly WIDTH cycles; ALUResult loads and done=1 in the cycle after the last busy cycle (latency WIDTH+1); busy=0 in that same cycle.
REQ-022 A start in the cycle where done=1 and busy=0 SHALL be accepted (back-to-back, no bubble).
REQ-023 ADD flags:
- carry = bit WIDTH of the (WIDTH+1)-bit sum.
- overflow = 1 when the operand signs are equal and the result sign differs.
REQ-024 SUB flags:
- carry = 1 when a<b unsigned (borrow).
- overflow = 1 when the operand signs differ and the result sign differs from a.
REQ-025 For ops other than ADD/SUB, carry and overflow SHALL be 0; zero SHALL follow ALUResult for every op.
REQ-026 ALUResult and all flags SHALL hold their values between done pulses, including throughout a multiply.
REQ-027 done SHALL never be high for more than one consecutive cycle per accepted request.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL set: state=IDLE, busy=0, done=0, ALUResult=0, zero=1, carry=0, overflow=0, counter=0, accumulator=0.
REQ-029 rst SHALL take priority over start in the same cycle; that request is discarded.
REQ-030 rst during MUL SHALL abort the multiply with no done pulse; a new request is accepted on the first edge after rst deasserts.

Verification (WIDTH=16, MUL_EN=1)
REQ-031 ADD a=0xFFFF, b=0x0001 -> next cycle done=1, ALUResult=0x0000, zero=1, carry=1, overflow=0.
REQ-032 SUB a=0x8000, b=0x0001 -> ALUResult=0x7FFF, overflow=1, carry=0; then SLT a=0xFFFF, b=0x0001 -> ALUResult=0x0001, zero=0.
REQ-033 MUL a=0x0123, b=0x0010 -> busy high for exactly 16 cycles, then done=1 with ALUResult=0x1230; a SUB start issued on busy cycle 3 is ignored (no extra done).
REQ-034 MUL a=0xFFFF, b=0xFFFF -> ALUResult=0x0001, carry=0, overflow=0; an ADD start in the done cycle produces a done in the very next cycle.
REQ-035 MUL started, rst=1 on busy cycle 5 -> next cycle busy=0, ALUResult=0, zero=1, no done for 20 cycles; a following ADD 2+3 gives 0x0005.
REQ-036 NOT a=0x0F0F -> 0xF0F0; XOR 0xAAAA^0xAAAA -> 0x0000 with zero=1.
